// File: rtl/fadd_sched.sv
// Round-robin share of one fadd pipeline between two requesters; results land in per-port FIFOs.
// Result visible LAT+1 cycles after accept; a port stalls (ready=0) when FIFO + in-flight would exceed DEPTH.
module fadd_sched #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  input  logic        req1_sub,
  output logic [31:0] fa_x1,
  output logic [31:0] fa_x2,
  input  logic [31:0] fa_y,
  input  logic        fa_ovf,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_y,
  output logic        resp0_ovf,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_y,
  output logic        resp1_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1);

  logic [1:0]          req_vld;
  logic [1:0]          elig;
  logic [1:0]          cand;
  logic [1:0]          grant;
  logic                rr_q;
  logic [LAT-1:0]      tag_vld_q;
  logic [LAT-1:0]      tag_id_q;
  logic [1:0][CW-1:0]  inflight;
  logic [1:0][CW-1:0]  fcnt;
  logic [1:0][32:0]    head;
  logic [1:0]          resp_rdy;
  logic [1:0]          resp_vld;
  logic                cap_vld;
  logic                cap_id;

  assign req_vld  = {req1_valid, req0_valid};
  assign resp_rdy = {resp1_ready, resp0_ready};
  assign cap_vld  = tag_vld_q[LAT-1];
  assign cap_id   = tag_id_q[LAT-1];

  always_comb begin
    inflight = '0;
    for (int s = 0; s < LAT; s++) begin
      if (tag_vld_q[s]) begin
        if (tag_id_q[s]) inflight[1] = inflight[1] + CW'(1);
        else             inflight[0] = inflight[0] + CW'(1);
      end
    end
  end

  // A slot is reserved for every in-flight op so the fadd output always has a home.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = ({1'b0, fcnt[i]} + {1'b0, inflight[i]}) < (CW+1)'(DEPTH);
  end

  always_comb begin
    cand  = req_vld & elig & {2{rstn}};
    grant = 2'b00;
    case (cand)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    fa_x1 = '0;
    fa_x2 = '0;
    if (grant[0]) begin
      fa_x1 = req0_x1;
      fa_x2 = {req0_x2[31] ^ req0_sub, req0_x2[30:0]};
    end else if (grant[1]) begin
      fa_x1 = req1_x1;
      fa_x2 = {req1_x2[31] ^ req1_sub, req1_x2[30:0]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q      <= 1'b1;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      if (|grant) rr_q <= grant[1];
      tag_vld_q[0] <= |grant;
      tag_id_q[0]  <= grant[1];
      for (int s = 1; s < LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push;
    logic          pop;

    assign pop  = resp_rdy[g] && (cnt_q != '0);
    assign push = cap_vld && (cap_id == 1'(g)) && ((cnt_q != CW'(DEPTH)) || pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
        if (push && !pop)      cnt_q <= cnt_q + CW'(1);
        else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= {fa_ovf, fa_y};
    end

    assign head[g]     = mem[rptr_q];
    assign fcnt[g]     = cnt_q;
    assign resp_vld[g] = (cnt_q != '0);
  end

  assign resp0_valid = resp_vld[0];
  assign resp0_y     = head[0][31:0];
  assign resp0_ovf   = head[0][32];
  assign resp1_valid = resp_vld[1];
  assign resp1_y     = head[1][31:0];
  assign resp1_ovf   = head[1][32];
endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: behavioural fadd in real arithmetic, per-port expected-result queues
// filled on accept and drained by a monitor whenever a response is presented.
module tb_fadd_sched;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x1 = '0, req0_x2 = '0, req1_x1 = '0, req1_x2 = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic [31:0] fa_x1, fa_x2, fa_y;
  logic        fa_ovf;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [31:0] resp0_y, resp1_y;
  logic        resp0_ovf, resp1_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc0 = 0, acc1 = 0;
  int glog[$];
  logic [32:0] q0[$], q1[$];
  logic [32:0] fa_pipe [LAT];

  fadd_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_sub(req1_sub),
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y), .fa_ovf(fa_ovf),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y), .resp0_ovf(resp0_ovf),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y), .resp1_ovf(resp1_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0) return 0.0;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [32:0] r2s(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0)   return {1'b0, d[63], 31'd0};
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    return {1'b0, d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [32:0] ref_resp(input logic [31:0] a, input logic [31:0] b, input logic sub);
    return r2s(sub ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b)));
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    e = ($urandom % 4 == 0) ? 8'd254 : 8'($urandom_range(100, 253));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Behavioural fadd: LAT register stages, non-stallable.
  always @(posedge clk) begin
    fa_pipe[0] <= r2s(s2r(fa_x1) + s2r(fa_x2));
    for (int s = 1; s < LAT; s++) fa_pipe[s] <= fa_pipe[s-1];
  end
  assign fa_y   = fa_pipe[LAT-1][31:0];
  assign fa_ovf = fa_pipe[LAT-1][32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (req0_valid && req1_valid) chk("grant_onehot", 64'(req0_ready & req1_ready), 64'd0);
      if (req0_valid && req0_ready) begin
        q0.push_back(ref_resp(req0_x1, req0_x2, req0_sub));
        acc0++;
        glog.push_back(0);
        chk("occupancy0", 64'(q0.size() <= DEPTH), 64'd1);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(ref_resp(req1_x1, req1_x2, req1_sub));
        acc1++;
        glog.push_back(1);
        chk("occupancy1", 64'(q1.size() <= DEPTH), 64'd1);
      end
      if (resp0_valid) begin
        if (q0.size() == 0) flag("resp0_spurious");
        else begin
          chk("resp0_head", 64'({resp0_ovf, resp0_y}), 64'(q0[0]));
          if (resp0_ready) void'(q0.pop_front());
        end
      end
      if (resp1_valid) begin
        if (q1.size() == 0) flag("resp1_spurious");
        else begin
          chk("resp1_head", 64'({resp1_ovf, resp1_y}), 64'(q1[0]));
          if (resp1_ready) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                      output int c, output logic [31:0] fx1, output logic [31:0] fx2);
    int n = 0;
    c = -1;
    fx1 = '0;
    fx2 = '0;
    if (p == 0) begin req0_x1 = a; req0_x2 = b; req0_sub = s; req0_valid = 1'b1; end
    else        begin req1_x1 = a; req1_x2 = b; req1_sub = s; req1_valid = 1'b1; end
    while (c < 0 && n < 20) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        c = cyc; fx1 = fa_x1; fx2 = fa_x2;
      end
      @(posedge clk); #1;
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (c < 0) flag("send_timeout");
  endtask

  task automatic wait_resp(input int p, output int c);
    int n = 0;
    c = -1;
    while (c < 0 && n < 20) begin
      @(negedge clk);
      if ((p == 0 && resp0_valid) || (p == 1 && resp1_valid)) c = cyc;
      n++;
    end
    if (c < 0) flag("resp_timeout");
  endtask

  task automatic drain();
    int n = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c, cr, a0s, a1s, a1m;
    logic [31:0] fx1, fx2;
    logic a0, a1;

    // Reset state with requests pending
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x1 = rnd_f(); req0_x2 = rnd_f(); req1_x1 = rnd_f(); req1_x2 = rnd_f();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_resp0_valid", 64'(resp0_valid), 64'd0);
    chk("rst_resp1_valid", 64'(resp1_valid), 64'd0);
    chk("rst_fa_x1", 64'(fa_x1), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Contention: alternating grants starting with port 0
    glog.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
      req0_x1 = rnd_f(); req0_x2 = rnd_f(); req0_sub = 1'($urandom);
      req1_x1 = rnd_f(); req1_x2 = rnd_f(); req1_sub = 1'($urandom);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("contend_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("contend_order", 64'(glog[i]), 64'(i % 2));
    drain();

    // Single op latency and value
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, c, fx1, fx2);
    wait_resp(0, cr);
    chk("single_latency", 64'(cr - c), 64'(LAT + 1));
    chk("single_y", 64'(resp0_y), 64'h4040_0000);
    chk("single_ovf", 64'(resp0_ovf), 64'd0);
    @(posedge clk); #1;

    // Subtract on port 1
    send(1, 32'h3F80_0000, 32'h4000_0000, 1'b1, c, fx1, fx2);
    chk("sub_fa_x1", 64'(fx1), 64'h3F80_0000);
    chk("sub_fa_x2", 64'(fx2), 64'hC000_0000);
    wait_resp(1, cr);
    chk("sub_y", 64'(resp1_y), 64'hBF80_0000);
    @(posedge clk); #1;
    drain();

    // Push and pop on the same edge with one entry held
    resp0_ready = 1'b0;
    send(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, c, fx1, fx2);
    wait_resp(0, cr);
    @(posedge clk); #1;
    send(0, 32'h4000_0000, 32'h4040_0000, 1'b0, c, fx1, fx2);
    repeat (LAT - 1) begin @(posedge clk); #1; end
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_valid", 64'(resp0_valid), 64'd1);
    chk("pushpop_head", 64'(resp0_y), 64'h40A0_0000);
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_empty", 64'(resp0_valid), 64'd0);
    @(posedge clk); #1;
    drain();

    // Backpressure on port 0 while port 1 streams
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    a0s = acc0; a1s = acc1;
    req0_x1 = rnd_f(); req0_x2 = rnd_f(); req1_x1 = rnd_f(); req1_x2 = rnd_f();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    a1m = acc1;
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_p1_stream", 64'(acc1 - a1m), 64'd5);
    chk("bp_p0_accepts", 64'(acc0 - a0s), 64'(DEPTH));
    @(negedge clk);
    chk("bp_p0_ready", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("bp_p0_after_pop", 64'(acc0 - a0s), 64'(DEPTH + 1));
    chk("bp_p1_total", 64'(acc1 - a1s > 10), 64'd1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || a0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_x1 = rnd_f(); req0_x2 = rnd_f(); req0_sub = 1'($urandom);
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_x1 = rnd_f(); req1_x2 = rnd_f(); req1_sub = 1'($urandom);
      end
      resp0_ready = ($urandom % 4) != 0;
      resp1_ready = ($urandom % 4) != 0;
    end
    drain();

    // Reset while two ops are in flight
    req0_x1 = rnd_f(); req0_x2 = rnd_f(); req1_x1 = rnd_f(); req1_x2 = rnd_f();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("midrst_req0_ready", 64'(req0_ready), 64'd0);
    chk("midrst_req1_ready", 64'(req1_ready), 64'd0);
    chk("midrst_resp0_valid", 64'(resp0_valid), 64'd0);
    chk("midrst_resp1_valid", 64'(resp1_valid), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_tie_p0", 64'(req0_ready), 64'd1);
    chk("postrst_tie_p1", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("postrst_acc_done", 64'(q0.size() + q1.size()), 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
endmodule
